// File: rtl/line_doubler.sv
// line_doubler: ping-pong scanline buffer between the PPU pixel stream and the
// VGA output stage. The PPU fills one bank while the VGA side replays the other
// REPEAT times, holding each pixel for HSCALE output cycles.
module line_doubler #(
   parameter int PIX_W    = 6,
   parameter int LINE_LEN = 256,
   parameter int REPEAT   = 2,
   parameter int HSCALE   = 2
) (
   input  logic             clock25,
   input  logic             reset_n,
   input  logic             wr_valid,
   input  logic [PIX_W-1:0] wr_data,
   input  logic             wr_eol,
   output logic             wr_ready,
   input  logic             rd_start,
   output logic             rd_valid,
   output logic [PIX_W-1:0] rd_data,
   output logic             rd_underrun,
   output logic             rd_overrun,
   output logic [1:0]       fill
);

   localparam int AW = $clog2(LINE_LEN);
   localparam int HW = (HSCALE > 1) ? $clog2(HSCALE) : 1;
   localparam int RW = 3;

   localparam logic [AW-1:0] LAST_PTR = AW'(LINE_LEN - 1);
   localparam logic [HW-1:0] LAST_H   = HW'(HSCALE - 1);
   localparam logic [RW-1:0] REP_INIT = RW'(REPEAT);

   typedef enum logic {S_IDLE, S_OUT} state_t;

   // Both banks live in one array; the bank select is the address MSB.
   logic [PIX_W-1:0] mem_q [2*LINE_LEN];

   logic [1:0]       full_q, full_d;
   logic             wbank_q, wbank_d;
   logic [AW-1:0]    wptr_q, wptr_d;

   state_t           state_q;
   logic             rbank_q;
   logic [RW-1:0]    rep_q;
   logic [HW-1:0]    hcnt_q;
   logic [AW-1:0]    rptr_q;
   logic             underrun_q;
   logic             overrun_q;
   logic [PIX_W-1:0] rdata_q;

   logic             wr_xfer;
   logic             wr_close;
   logic [AW:0]      wr_addr;

   logic             rd_out;
   logic             rd_accept;
   logic             rd_last;
   logic             rd_release;
   logic             rd_en;
   logic [AW-1:0]    rd_ptr_nxt;
   logic [AW:0]      rd_addr;

   // Writer side: a pixel moves whenever the current write bank is not full.
   assign wr_ready = ~full_q[wbank_q];
   assign wr_xfer  = wr_valid & wr_ready;
   assign wr_close = wr_xfer & (wr_eol | (wptr_q == LAST_PTR));
   assign wr_addr  = {wbank_q, wptr_q};

   // Reader side decode. The RAM has one cycle of read latency, so the address
   // issued in a cycle is the pixel shown in the next one: on accept that is
   // pixel 0, inside OUT it is the pixel after the current hold slot.
   assign rd_out     = (state_q == S_OUT);
   assign rd_accept  = (state_q == S_IDLE) & rd_start & full_q[rbank_q];
   assign rd_last    = rd_out & (hcnt_q == LAST_H) & (rptr_q == LAST_PTR);
   assign rd_release = rd_last & (rep_q == RW'(1));
   assign rd_en      = rd_accept | (rd_out & ~rd_last);
   assign rd_addr    = {rbank_q, rd_ptr_nxt};

   // Next pixel to fetch for the following output cycle.
   always_comb begin
      rd_ptr_nxt = '0;
      if (rd_out) begin
         if (hcnt_q == LAST_H) rd_ptr_nxt = rptr_q + AW'(1);
         else                  rd_ptr_nxt = rptr_q;
      end
   end

   // Write bank/pointer advance; a closed line hands the bank to the reader.
   always_comb begin
      wbank_d = wbank_q;
      wptr_d  = wptr_q;
      if (wr_close) begin
         wbank_d = ~wbank_q;
         wptr_d  = '0;
      end else if (wr_xfer) begin
         wptr_d  = wptr_q + AW'(1);
      end
   end

   // Bank occupancy: the writer only sets a non-full bank and the reader only
   // clears a full one, so both updates can land in the same cycle.
   always_comb begin
      full_d = full_q;
      if (wr_close)   full_d[wbank_q] = 1'b1;
      if (rd_release) full_d[rbank_q] = 1'b0;
   end

   // Writer state and bank-full flags.
   always_ff @(posedge clock25) begin
      if (!reset_n) begin
         full_q  <= '0;
         wbank_q <= 1'b0;
         wptr_q  <= '0;
      end else begin
         full_q  <= full_d;
         wbank_q <= wbank_d;
         wptr_q  <= wptr_d;
      end
   end

   // RAM write port; contents survive reset.
   always_ff @(posedge clock25) begin
      if (wr_xfer) mem_q[wr_addr] <= wr_data;
   end

   // RAM read port; the output register is forced to zero outside a line.
   always_ff @(posedge clock25) begin
      if (!reset_n)   rdata_q <= '0;
      else if (rd_en) rdata_q <= mem_q[rd_addr];
      else            rdata_q <= '0;
   end

   // Reader FSM: replays the full bank REPEAT times, then releases it.
   always_ff @(posedge clock25) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         rbank_q    <= 1'b0;
         rep_q      <= '0;
         hcnt_q     <= '0;
         rptr_q     <= '0;
         underrun_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         underrun_q <= 1'b0;
         overrun_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (rd_start) begin
                  if (full_q[rbank_q]) begin
                     state_q <= S_OUT;
                     hcnt_q  <= '0;
                     rptr_q  <= '0;
                     if (rep_q == '0) rep_q <= REP_INIT;
                  end else begin
                     underrun_q <= 1'b1;
                  end
               end
            end
            S_OUT: begin
               overrun_q <= rd_start;
               if (hcnt_q == LAST_H) begin
                  hcnt_q <= '0;
                  rptr_q <= rptr_q + AW'(1);
               end else begin
                  hcnt_q <= hcnt_q + HW'(1);
               end
               if (rd_last) begin
                  state_q <= S_IDLE;
                  rep_q   <= rep_q - RW'(1);
                  if (rep_q == RW'(1)) rbank_q <= ~rbank_q;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign rd_valid    = rd_out;
   assign rd_data     = rdata_q;
   assign rd_underrun = underrun_q;
   assign rd_overrun  = overrun_q;
   assign fill        = {1'b0, full_q[0]} + {1'b0, full_q[1]};

endmodule
